// File: rtl/dwt_fir_pkg.sv
// Shared helpers for the DWT FIR branch.
//   clog2      : ceiling log2 for parameter derivation
//   w_acc      : accumulator width of a branch (W_IN + C_IN + clog2(N_TAPS))
//   lat        : input-to-output latency of a branch in cycles
//   round_sat  : round-half-up right shift followed by clamp (or pass-through
//                for wrap mode) on a 64-bit signed value. The caller keeps
//                the low Y_OUT bits, so wrap mode is just truncation there.
package dwt_fir_pkg;

  typedef logic signed [63:0] wide_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int w_acc(input int w_in, input int c_in, input int n_taps);
    return w_in + c_in + clog2(n_taps);
  endfunction

  function automatic int lat(input int n_taps);
    return clog2(n_taps) + 2;
  endfunction

  // Working in 64 bits keeps the rounding constant from overflowing the
  // accumulator and makes sign extension to a wide Y_OUT automatic.
  function automatic wide_t round_sat(input wide_t acc, input int shift,
                                      input bit sat, input int y_out);
    wide_t s;
    wide_t hi;
    wide_t lo;
    s = acc;
    if (shift > 0) s = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    if (sat) begin
      hi = (64'sd1 <<< (y_out - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (y_out - 1));
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/dwt_fir_branch_if.sv
// Sample / coefficient / result bundle of one FIR branch.
//   clear      : zero delay line and kill in-flight results
//   in_valid   : in_data carries a new sample
//   in_data    : signed sample, W_IN bits
//   coef_we    : coefficient write strobe
//   coef_addr  : tap index, clog2(N_TAPS) bits
//   coef_data  : signed coefficient, C_IN bits
//   out_valid  : out_data holds a new filter output
//   out_data   : signed filter output, Y_OUT bits
// master = sample source / controller, slave = the filter branch.
interface dwt_fir_branch_if
  import dwt_fir_pkg::*;
#(
  parameter int W_IN   = 7,
  parameter int C_IN   = 5,
  parameter int N_TAPS = 4,
  parameter int Y_OUT  = 20
) ();
  localparam int A_W = clog2(N_TAPS);

  logic                    clear;
  logic                    in_valid;
  logic signed [W_IN-1:0]  in_data;
  logic                    coef_we;
  logic [A_W-1:0]          coef_addr;
  logic signed [C_IN-1:0]  coef_data;
  logic                    out_valid;
  logic signed [Y_OUT-1:0] out_data;

  modport master (
    output clear, in_valid, in_data, coef_we, coef_addr, coef_data,
    input  out_valid, out_data
  );

  modport slave (
    input  clear, in_valid, in_data, coef_we, coef_addr, coef_data,
    output out_valid, out_data
  );
endinterface

// File: rtl/dwt_add_tree.sv
// Pipelined signed adder tree with a valid tag.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : drops all valid tags (data registers keep their values)
//   in_valid  : tag for the current leaves
//   leaves    : N signed operands, W bits each
//   out_valid : tag delayed by clog2(N) cycles
//   sum       : sum of the leaves, W + clog2(N) bits, one register per level
// The tree is laid out as a heap: node 1 is the root, node i has children
// 2i and 2i+1, and children at index >= N_PAD are leaves. Leaves past N are
// tied to zero so a non-power-of-2 N still has equal-depth paths. All nodes
// carry the full output width, which is exact for every level.
module dwt_add_tree
  import dwt_fir_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic signed [W-1:0]           leaves [N],
  output logic                          out_valid,
  output logic signed [W+clog2(N)-1:0]  sum
);
  localparam int N_LVL = clog2(N);
  localparam int N_PAD = 1 << N_LVL;
  localparam int W_OUT = W + N_LVL;

  logic signed [W_OUT-1:0] leaf_ext [N_PAD];
  logic signed [W_OUT-1:0] node_reg [1:N_PAD-1];
  logic [N_LVL-1:0]        vld_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_PAD; gi++) begin : gen_leaf
      if (gi < N) begin : gen_real
        assign leaf_ext[gi] = W_OUT'(leaves[gi]);
      end else begin : gen_pad
        assign leaf_ext[gi] = '0;
      end
    end

    for (gi = 1; gi < N_PAD; gi++) begin : gen_node
      logic signed [W_OUT-1:0] op_a;
      logic signed [W_OUT-1:0] op_b;
      if (2 * gi >= N_PAD) begin : gen_from_leaf
        assign op_a = leaf_ext[2 * gi - N_PAD];
        assign op_b = leaf_ext[2 * gi + 1 - N_PAD];
      end else begin : gen_from_node
        assign op_a = node_reg[2 * gi];
        assign op_b = node_reg[2 * gi + 1];
      end
      always_ff @(posedge clk) begin
        if (rst) node_reg[gi] <= '0;
        else     node_reg[gi] <= op_a + op_b;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= in_valid;
      for (int i = 1; i < N_LVL; i++) vld_reg[i] <= vld_reg[i-1];
    end
  end

  assign sum       = node_reg[1];
  assign out_valid = vld_reg[N_LVL-1];
endmodule

// File: rtl/dwt_fir_branch.sv
// One polyphase FIR branch of the DWT filter bank: y[n] = sum c[k]*x[n-k].
//   clk, rst : clock, synchronous active-high reset
//   bus      : dwt_fir_branch_if.slave (samples, coefficient writes, clear,
//              filter output)
// Pipeline: registered products -> clog2(N_TAPS) adder levels -> registered
// round/saturate stage, so a sample presented in cycle t appears in cycle
// t + clog2(N_TAPS) + 2. A valid tag travels with the data; clear kills it.
module dwt_fir_branch
  import dwt_fir_pkg::*;
#(
  parameter int W_IN   = 7,
  parameter int C_IN   = 5,
  parameter int N_TAPS = 4,
  parameter int Y_OUT  = 20,
  parameter int SHIFT  = 0,
  parameter int SAT    = 1
) (
  input logic               clk,
  input logic               rst,
  dwt_fir_branch_if.slave   bus
);
  localparam int W_PROD = W_IN + C_IN;
  localparam int W_ACC  = w_acc(W_IN, C_IN, N_TAPS);
  localparam int A_W    = clog2(N_TAPS);

  logic signed [W_IN-1:0]   d_reg    [N_TAPS-1];
  logic signed [W_IN-1:0]   operand  [N_TAPS];
  logic signed [C_IN-1:0]   coef_reg [N_TAPS];
  logic signed [W_PROD-1:0] prod_reg [N_TAPS];
  logic                     prod_vld_reg;
  logic signed [W_ACC-1:0]  acc;
  logic                     acc_vld;
  logic                     out_valid_reg;
  logic signed [Y_OUT-1:0]  out_data_reg;
  wide_t                    scaled;

  // Tap 0 multiplies the live sample; the delay line feeds taps 1..N-1.
  assign operand[0] = bus.in_data;

  genvar gi;
  generate
    for (gi = 0; gi < N_TAPS - 1; gi++) begin : gen_dly
      assign operand[gi+1] = d_reg[gi];
      if (gi == 0) begin : gen_head
        always_ff @(posedge clk) begin
          if (rst || bus.clear)  d_reg[gi] <= '0;
          else if (bus.in_valid) d_reg[gi] <= bus.in_data;
        end
      end else begin : gen_body
        always_ff @(posedge clk) begin
          if (rst || bus.clear)  d_reg[gi] <= '0;
          else if (bus.in_valid) d_reg[gi] <= d_reg[gi-1];
        end
      end
    end

    // The product register reads coef_reg before this edge's write lands,
    // so a same-cycle write only affects later samples.
    for (gi = 0; gi < N_TAPS; gi++) begin : gen_tap
      always_ff @(posedge clk) begin
        if (rst)
          coef_reg[gi] <= '0;
        else if (bus.coef_we && bus.coef_addr == A_W'(gi))
          coef_reg[gi] <= bus.coef_data;
      end

      always_ff @(posedge clk) begin
        if (rst) prod_reg[gi] <= '0;
        else     prod_reg[gi] <= W_PROD'(operand[gi]) * W_PROD'(coef_reg[gi]);
      end
    end
  endgenerate

  // clear also drops the sample arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) prod_vld_reg <= 1'b0;
    else                  prod_vld_reg <= bus.in_valid;
  end

  dwt_add_tree #(
    .N (N_TAPS),
    .W (W_PROD)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.clear),
    .in_valid  (prod_vld_reg),
    .leaves    (prod_reg),
    .out_valid (acc_vld),
    .sum       (acc)
  );

  assign scaled = round_sat(wide_t'(acc), SHIFT, SAT != 0, Y_OUT);

  generate
    if (Y_OUT < 64) begin : gen_hi
      logic unused_hi;
      assign unused_hi = ^scaled[63:Y_OUT];
    end
  endgenerate

  // out_data only moves with a surviving valid tag; it holds through clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= acc_vld && !bus.clear;
      if (acc_vld && !bus.clear) out_data_reg <= scaled[Y_OUT-1:0];
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
endmodule

// File: tb/tb_dwt_fir_branch.sv
// Bench for dwt_fir_branch: four instances (N_TAPS=4) with different output
// configurations share one stimulus stream. A behavioural model computes
// y[n] from the sample history and coefficient table, schedules it LAT cycles
// later, and a single negedge process compares every instance every cycle.
module tb_dwt_fir_branch;
  localparam int NDUT = 4;
  localparam int YO_T  [NDUT] = '{20, 8, 8, 8};
  localparam int SH_T  [NDUT] = '{0, 0, 0, 2};
  localparam int SAT_T [NDUT] = '{1, 1, 0, 1};
  localparam int LAT  = 4;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              clear;
  logic              in_valid;
  logic signed [6:0] in_data;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic signed [4:0] coef_data;

  logic              dut_vld [NDUT];
  logic signed [63:0] dut_dat [NDUT];

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : gen_dut
      dwt_fir_branch_if #(.W_IN(7), .C_IN(5), .N_TAPS(4), .Y_OUT(YO_T[gi])) bus ();
      assign bus.clear     = clear;
      assign bus.in_valid  = in_valid;
      assign bus.in_data   = in_data;
      assign bus.coef_we   = coef_we;
      assign bus.coef_addr = coef_addr;
      assign bus.coef_data = coef_data;
      assign dut_vld[gi]   = bus.out_valid;
      assign dut_dat[gi]   = 64'(bus.out_data);
      dwt_fir_branch #(
        .W_IN(7), .C_IN(5), .N_TAPS(4), .Y_OUT(YO_T[gi]),
        .SHIFT(SH_T[gi]), .SAT(SAT_T[gi])
      ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  int     vectors = 0;
  int     miscompares = 0;
  int     edge_n = 0;
  bit     checking = 1'b0;
  bit     exp_vld [NDUT][MAXC];
  longint exp_dat [NDUT][MAXC];
  bit     rst_at  [MAXC];
  longint m_coef  [4];
  longint m_hist  [4];
  longint last_exp [NDUT];
  longint last_got [NDUT];
  int     got0[$];
  int     got3[$];
  int     first_vld_edge = -1;
  int     imp_exp [5] = '{1, 2, 3, 4, 0};
  int     rnd_exp [3] = '{2, -1, 1};

  // Expected output: optional round-half-up shift, then clamp or wrap.
  function automatic longint ref_out(input longint y, input int sh, input int sat, input int yo);
    longint s, m, hi, lo;
    s = y;
    if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
    m  = longint'(1) << yo;
    hi = m / 2 - 1;
    lo = -(m / 2);
    if (sat != 0) begin
      if (s > hi) s = hi;
      if (s < lo) s = lo;
    end else begin
      s = ((s % m) + m) % m;
      if (s > hi) s = s - m;
    end
    return s;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  task automatic kill_from(input int e);
    for (int d = 0; d < NDUT; d++)
      for (int k = 0; k <= LAT; k++) exp_vld[d][e + k] = 1'b0;
  endtask

  // One clock of stimulus; the model advances at the same edge.
  task automatic step(input bit r, input bit clr, input bit iv, input int x,
                      input bit we, input int a, input int cd);
    longint y;
    rst = r; clear = clr; in_valid = iv; in_data = 7'(x);
    coef_we = we; coef_addr = 2'(a); coef_data = 5'(cd);
    @(posedge clk);
    edge_n++;
    if (edge_n + LAT + 1 >= MAXC) begin
      $display("FAIL cycle_budget: got %0d, expected below %0d", edge_n, MAXC - LAT - 1);
      $fatal(1, "cycle budget exhausted");
    end
    if (r) begin
      rst_at[edge_n] = 1'b1;
      kill_from(edge_n);
      for (int k = 0; k < 4; k++) begin m_coef[k] = 0; m_hist[k] = 0; end
    end else begin
      if (clr) kill_from(edge_n);
      if (iv && !clr) begin
        for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = x;
        y = 0;
        for (int k = 0; k < 4; k++) y += m_coef[k] * m_hist[k];
        for (int d = 0; d < NDUT; d++) begin
          exp_vld[d][edge_n + LAT - 1] = 1'b1;
          exp_dat[d][edge_n + LAT - 1] = ref_out(y, SH_T[d], SAT_T[d], YO_T[d]);
        end
      end
      if (we) m_coef[a] = cd;
      if (clr) for (int k = 0; k < 4; k++) m_hist[k] = 0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic samp(input int x);
    step(0, 0, 1, x, 0, 0, 0);
  endtask

  task automatic setc(input int c0, input int c1, input int c2, input int c3);
    step(0, 0, 0, 0, 1, 0, c0);
    step(0, 0, 0, 0, 1, 1, c1);
    step(0, 0, 0, 0, 1, 2, c2);
    step(0, 0, 0, 0, 1, 3, c3);
  endtask

  task automatic chk_impulse(input string name);
    chk({name, "_count"}, got0.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got0.size()) chk({name, "_y"}, got0[i], imp_exp[i]);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < NDUT; d++) begin
        if (rst_at[edge_n]) last_exp[d] = 0;
        if (exp_vld[d][edge_n]) last_exp[d] = exp_dat[d][edge_n];
        vectors++;
        if (dut_vld[d] !== exp_vld[d][edge_n]) begin
          miscompares++;
          $display("FAIL out_valid dut%0d edge %0d: got %0b, expected %0b",
                   d, edge_n, dut_vld[d], exp_vld[d][edge_n]);
        end
        vectors++;
        if (dut_dat[d] !== last_exp[d]) begin
          miscompares++;
          $display("FAIL out_data dut%0d edge %0d: got %0d, expected %0d",
                   d, edge_n, dut_dat[d], last_exp[d]);
        end
        if (dut_vld[d] === 1'b1) begin
          last_got[d] = dut_dat[d];
          if (d == 0) begin
            got0.push_back(int'(dut_dat[d]));
            if (first_vld_edge < 0) first_vld_edge = edge_n;
          end
          if (d == 3) got3.push_back(int'(dut_dat[d]));
        end
      end
    end
  end

  initial begin
    int x_edge;
    bit r, clr, iv, we;
    int x, a, cd;

    for (int k = 0; k < 4; k++) begin m_coef[k] = 0; m_hist[k] = 0; end
    for (int d = 0; d < NDUT; d++) begin last_exp[d] = 0; last_got[d] = 0; end

    step(1, 0, 0, 0, 0, 0, 0);
    checking = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Model anchors for the output stage.
    chk("model_round_pos", ref_out(6, 2, 1, 8), 2);
    chk("model_round_neg", ref_out(-6, 2, 1, 8), -1);
    chk("model_round_5", ref_out(5, 2, 1, 8), 1);
    chk("model_clamp", ref_out(4096, 0, 1, 8), 127);
    chk("model_wrap", ref_out(4096, 0, 0, 8), 0);

    // Impulse response with back-to-back samples.
    setc(1, 2, 3, 4);
    got0.delete(); first_vld_edge = -1;
    samp(1); x_edge = edge_n;
    for (int i = 0; i < 4; i++) samp(0);
    idle(6);
    chk_impulse("impulse");
    chk("impulse_latency", first_vld_edge - (x_edge - 1), 4);

    // Same impulse with idle cycles between samples.
    got0.delete();
    samp(1); idle(1);
    for (int i = 0; i < 4; i++) begin samp(0); idle(1); end
    idle(6);
    chk_impulse("bubbles");

    // Saturation / wrap: 4 * (-16) * (-64) = 4096.
    setc(-16, -16, -16, -16);
    for (int i = 0; i < 4; i++) samp(-64);
    idle(6);
    chk("sat_wide", last_got[0], 4096);
    chk("sat_clamp", last_got[1], 127);
    chk("sat_wrap", last_got[2], 0);
    chk("sat_shift_clamp", last_got[3], 127);

    // Rounding on the SHIFT=2 instance.
    setc(1, 0, 0, 0);
    got3.delete();
    samp(6); samp(-6); samp(5);
    idle(6);
    chk("round_count", got3.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got3.size()) chk("round_y", got3[i], rnd_exp[i]);

    // Coefficient write colliding with a sample.
    setc(1, 2, 3, 4);
    step(0, 1, 0, 0, 0, 0, 0);
    got0.delete();
    step(0, 0, 1, 1, 1, 0, 7);
    samp(1);
    idle(6);
    chk("coef_count", got0.size(), 2);
    if (got0.size() > 0) chk("coef_old", got0[0], 1);
    if (got0.size() > 1) chk("coef_new", got0[1], 9);

    // clear with two samples in flight plus a same-cycle sample.
    setc(1, 2, 3, 4);
    got0.delete();
    samp(1); samp(1);
    step(0, 1, 1, 1, 0, 0, 0);
    idle(6);
    chk("clear_kill", got0.size(), 0);
    samp(1);
    for (int i = 0; i < 4; i++) samp(0);
    idle(6);
    chk_impulse("after_clear");

    // rst zeroes the coefficient bank.
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    got0.delete();
    samp(5);
    idle(6);
    chk("rst_count", got0.size(), 1);
    if (got0.size() > 0) chk("rst_coef_zero", got0[0], 0);

    // Randomised traffic.
    setc(3, -5, 7, -2);
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(0, 399) == 0);
      clr = ($urandom_range(0, 49) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      x   = int'($urandom_range(0, 127)) - 64;
      we  = ($urandom_range(0, 9) == 0);
      a   = int'($urandom_range(0, 3));
      cd  = int'($urandom_range(0, 31)) - 16;
      step(r, clr, iv, x, we, a, cd);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
